// File: rtl/prga_decrypt.sv
// RC4 pseudo-random generation and decryption engine.
// Continues the permutation of the S array left by key scheduling, XORs the
// keystream with the ciphertext ROM, writes plaintext and aborts on the first
// byte that is neither a space nor a lowercase letter.
module prga_decrypt #(
  parameter int unsigned MSG_LEN = 32
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic       bad_char,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  input  logic [7:0] s_rddata,
  output logic [4:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [4:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  typedef enum logic [3:0] {
    StIdle,
    StInc,
    StRdI,
    StCapI,
    StRdJ,
    StCapJ,
    StWrI,
    StWrJ,
    StRdF,
    StCapF,
    StWrPt,
    StDone
  } state_e;

  localparam logic [4:0] LastK = 5'(MSG_LEN - 1);

  state_e     state_q;
  logic [7:0] i_q, j_q, si_q, sj_q, f_q, ct_q;
  logic [4:0] k_q;
  logic       bad_q;
  logic       done_q;

  logic [7:0] pt_byte;
  logic       byte_ok;

  assign pt_byte = f_q ^ ct_q;
  assign byte_ok = (pt_byte == 8'h20) || ((pt_byte >= 8'h61) && (pt_byte <= 8'h7a));

  // Sequencer: one keystream byte per pass through INC..WR_PT.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      f_q     <= '0;
      ct_q    <= '0;
      k_q     <= '0;
      bad_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // done is a registered view of the DONE state, so it trails it by a cycle
      done_q <= (state_q == StDone);
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            bad_q   <= 1'b0;
            state_q <= StInc;
          end
        end
        StInc: begin
          i_q     <= i_q + 8'd1;
          state_q <= StRdI;
        end
        StRdI: state_q <= StCapI;
        StCapI: begin
          si_q    <= s_rddata;
          j_q     <= j_q + s_rddata;
          state_q <= StRdJ;
        end
        StRdJ: state_q <= StCapJ;
        StCapJ: begin
          sj_q    <= s_rddata;
          state_q <= StWrI;
        end
        StWrI: state_q <= StWrJ;
        StWrJ: state_q <= StRdF;
        StRdF: state_q <= StCapF;
        StCapF: begin
          f_q     <= s_rddata;
          ct_q    <= ct_rddata;
          state_q <= StWrPt;
        end
        StWrPt: begin
          if (!byte_ok) begin
            bad_q   <= 1'b1;
            state_q <= StDone;
          end else if (k_q == LastK) begin
            state_q <= StDone;
          end else begin
            k_q     <= k_q + 5'd1;
            state_q <= StInc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory strobes decoded from the current state; i==j needs no special case.
  always_comb begin
    s_addr   = 8'h00;
    s_wrdata = 8'h00;
    s_wren   = 1'b0;
    pt_wren  = 1'b0;
    unique case (state_q)
      StRdI: s_addr = i_q;
      StRdJ: s_addr = j_q;
      StWrI: begin
        s_addr   = i_q;
        s_wrdata = sj_q;
        s_wren   = 1'b1;
      end
      StWrJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
      end
      StRdF:  s_addr = si_q + sj_q;
      StWrPt: pt_wren = 1'b1;
      default: ;
    endcase
  end

  assign ct_addr   = k_q;
  assign pt_addr   = k_q;
  assign pt_wrdata = pt_byte;
  assign done      = done_q;
  assign bad_char  = bad_q;

endmodule
